// File: rtl/id_fsm_param.sv
// Streaming identifier recogniser: flags a letter run followed by a legal-length digit run.
// Build option: define ID_UNDERSCORE_EN to treat '_' (0x5F) as a letter.
module id_fsm_param #(
    parameter int CHAR_W     = 8,
    parameter int MIN_DIGITS = 1,
    parameter int MAX_DIGITS = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    // Handshake: char is consumed on every rising edge where char_valid=1.
    // There is no ready signal, so the source never sees backpressure.
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char,
    input  logic              clr_cnt,
    output logic              out,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [1:0]        state_dbg
);

    localparam int DSAT = ((MAX_DIGITS > MIN_DIGITS) ? MAX_DIGITS : MIN_DIGITS) + 1;
    localparam int DW   = $clog2(DSAT + 1);
    localparam logic [DW-1:0] DSAT_V = DW'(DSAT);
    localparam logic [DW-1:0] MIN_V  = DW'(MIN_DIGITS);
    localparam logic [DW-1:0] MAX_V  = DW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALPHA = 2'd1,
        DIGIT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n, dinc;
    logic          out_n, pulse_n;
    logic [6:0]    lo;
    logic          hi_set, is_letter, is_digit, is_us;

    // Any set bit above the 7-bit ASCII range makes the character "other".
    assign lo       = char[6:0];
    assign hi_set   = (char >> 7) != '0;
    assign is_digit = !hi_set && (lo >= 7'h30) && (lo <= 7'h39);
`ifdef ID_UNDERSCORE_EN
    assign is_us    = (lo == 7'h5F);
`else
    assign is_us    = 1'b0;
`endif
    assign is_letter = !hi_set && (((lo >= 7'h41) && (lo <= 7'h5A)) ||
                                   ((lo >= 7'h61) && (lo <= 7'h7A)) || is_us);

    assign state_dbg = state;

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        dinc    = (dcnt == DSAT_V) ? dcnt : dcnt + DW'(1);
        if (char_valid) begin
            if (is_letter) begin
                state_n = ALPHA;
                dcnt_n  = '0;
            end else if (is_digit) begin
                case (state)
                    ALPHA: begin
                        state_n = DIGIT;
                        dcnt_n  = DW'(1);
                    end
                    DIGIT: begin
                        // A run longer than MAX_DIGITS kills the token until the next letter.
                        if ((MAX_DIGITS != 0) && (dinc > MAX_V)) begin
                            state_n = IDLE;
                            dcnt_n  = '0;
                        end else begin
                            dcnt_n  = dinc;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        dcnt_n  = '0;
                    end
                endcase
            end else begin
                state_n = IDLE;
                dcnt_n  = '0;
            end
        end
        out_n   = char_valid ? ((state_n == DIGIT) && (dcnt_n >= MIN_V)) : out;
        pulse_n = char_valid && out_n && !out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dcnt        <= '0;
            out         <= 1'b0;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
        end else begin
            state       <= state_n;
            dcnt        <= dcnt_n;
            out         <= out_n;
            match_pulse <= pulse_n;
            // Clear beats a coincident increment; the count sticks at all-ones.
            if (clr_cnt)
                match_cnt <= '0;
            else if (pulse_n && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_fsm_param.sv
// Bench for id_fsm_param: three parameterisations share one stimulus stream and are
// compared against a trailing-run model through an expected-value queue.
module tb_id_fsm_param;

    logic        clk;
    logic        reset;
    logic        char_valid;
    logic [7:0]  char;
    logic        clr_cnt;

    logic        out_a, pulse_a, out_b, pulse_b, out_c, pulse_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;
    logic [1:0]  st_a, st_b, st_c;

    id_fsm_param #(.CHAR_W(8), .MIN_DIGITS(1), .MAX_DIGITS(0), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char), .clr_cnt(clr_cnt),
        .out(out_a), .match_pulse(pulse_a), .match_cnt(cnt_a), .state_dbg(st_a));

    id_fsm_param #(.CHAR_W(8), .MIN_DIGITS(2), .MAX_DIGITS(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char), .clr_cnt(clr_cnt),
        .out(out_b), .match_pulse(pulse_b), .match_cnt(cnt_b), .state_dbg(st_b));

    id_fsm_param #(.CHAR_W(8), .MIN_DIGITS(1), .MAX_DIGITS(0), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char), .clr_cnt(clr_cnt),
        .out(out_c), .match_pulse(pulse_c), .match_cnt(cnt_c), .state_dbg(st_c));

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // One entry per cycle: {out,pulse,cnt[15:0]} for dut a, b, c.
    logic [53:0] exp_q[$];

    // Reference: class of last non-digit char since reset (0 none, 1 letter, 2 other)
    // and the number of digits seen after it.
    int min_d[3] = '{1, 2, 1};
    int max_d[3] = '{0, 3, 0};
    int cmax[3]  = '{65535, 65535, 3};
    int lastnd[3];
    int td[3];
    bit mout[3];
    int mcnt[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int cls(input logic [7:0] c);
        if (c inside {[8'h41:8'h5A], [8'h61:8'h7A]}) return 1;
`ifdef ID_UNDERSCORE_EN
        if (c == 8'h5F) return 1;
`endif
        if (c inside {[8'h30:8'h39]}) return 3;
        return 2;
    endfunction

    function automatic logic [53:0] pack_model(input bit p0, input bit p1, input bit p2);
        logic [17:0] e0, e1, e2;
        e0 = {mout[0], p0, 16'(mcnt[0])};
        e1 = {mout[1], p1, 16'(mcnt[1])};
        e2 = {mout[2], p2, 16'(mcnt[2])};
        return {e0, e1, e2};
    endfunction

    task automatic compare_cycle();
        logic [53:0] e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("out_a",   {31'd0, out_a},   {31'd0, e[53]});
            check("pulse_a", {31'd0, pulse_a}, {31'd0, e[52]});
            check("cnt_a",   {16'd0, cnt_a},   {16'd0, e[51:36]});
            check("out_b",   {31'd0, out_b},   {31'd0, e[35]});
            check("pulse_b", {31'd0, pulse_b}, {31'd0, e[34]});
            check("cnt_b",   {16'd0, cnt_b},   {16'd0, e[33:18]});
            check("out_c",   {31'd0, out_c},   {31'd0, e[17]});
            check("pulse_c", {31'd0, pulse_c}, {31'd0, e[16]});
            check("cnt_c",   {30'd0, cnt_c},   {16'd0, e[15:0]});
        end
    endtask

    // driver tasks
    task automatic drive(input bit v, input logic [7:0] c, input bit clr);
        bit p[3];
        bit nout;
        int k;
        @(negedge clk);
        reset      = 1'b0;
        char_valid = v;
        char       = c;
        clr_cnt    = clr;
        for (int i = 0; i < 3; i++) begin
            p[i] = 1'b0;
            if (v) begin
                k = cls(c);
                if (k == 3) td[i]++;
                else begin
                    lastnd[i] = k;
                    td[i]     = 0;
                end
                nout = (lastnd[i] == 1) && (td[i] >= min_d[i]) &&
                       ((max_d[i] == 0) || (td[i] <= max_d[i]));
                p[i]    = nout && !mout[i];
                mout[i] = nout;
            end
            if (clr) mcnt[i] = 0;
            else if (p[i] && (mcnt[i] != cmax[i])) mcnt[i]++;
        end
        exp_q.push_back(pack_model(p[0], p[1], p[2]));
        @(posedge clk);
        #1;
        compare_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        char_valid = 1'b1;
        char       = 8'h61;
        clr_cnt    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lastnd[i] = 0;
            td[i]     = 0;
            mout[i]   = 1'b0;
            mcnt[i]   = 0;
        end
        exp_q.push_back(pack_model(1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        compare_cycle();
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0);
    endtask

    logic [7:0] pool[16] = '{8'h61, 8'h5A, 8'h5F, 8'h30, 8'h39, 8'h35, 8'h20, 8'hC1,
                             8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A, 8'h31};

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char       = 8'h00;
        clr_cnt    = 1'b0;
        do_reset();

        send("a1");
        send(" ab123 9");
        send(" x1234 x12y34");
        // letter with high bit set must not count as a letter
        send(" a");
        drive(1'b1, 8'hC1, 1'b0);
        send("1");
        // stall holds state
        send(" a");
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h37, 1'b0);
        send("5");
        // reset mid-token discards the letter
        send(" a");
        do_reset();
        send("5");
        send(" _a1 a_1 ");
        // saturation on the narrow counter, then clear coincident with a pulse
        drive(1'b0, 8'h20, 1'b1);
        for (int i = 0; i < 4; i++) send("a1 ");
        send("a");
        drive(1'b1, 8'h31, 1'b1);
        send(" ");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) do_reset();
            else drive($urandom_range(0, 3) != 0, pool[$urandom_range(0, 15)],
                       $urandom_range(0, 15) == 0);
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
